// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial-to-parallel frame receiver. Consumes one line bit per sample strobe
// and recognises a frame of: start bit (0), DATA_W data bits (LSB first),
// an optional parity bit, and a stop bit (1). A good frame updates data_out
// and pulses data_valid; parity or framing violations pulse an error flag
// and the word is dropped.
//
// Parameters:
//   DATA_W     - data bits per frame (>= 1)
//   PARITY_EN  - 1: a parity bit follows the data bits; 0: no parity bit
//   PARITY_ODD - 0: even parity; 1: odd parity
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   bit_en     - sample strobe; din is consumed only when bit_en = 1
//   din        - serial line bit, idle level 1
//   data_out   - last correctly received word
//   data_valid - one-cycle pulse: data_out updated with a good frame
//   parity_err - one-cycle pulse: parity mismatch, word dropped
//   frame_err  - one-cycle pulse: stop bit sampled as 0, word dropped
//   busy       - high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0]  shreg, shreg_nx;
  logic               par_bit, par_bit_nx;
  logic               valid_nx, perr_nx, ferr_nx;
  logic               parity_ok;

  // Data ones, the received parity bit and the odd/even selector must XOR
  // to zero. Without a parity bit every stop-1 frame is good.
  assign parity_ok = PARITY_EN ? ~(^shreg ^ par_bit ^ PARITY_ODD) : 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state and pulse decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_bit_nx = par_bit;
    valid_nx   = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;

    if (bit_en) begin
      unique case (state)
        S_IDLE: begin
          if (!din) begin
            state_nx   = S_DATA;
            bit_cnt_nx = '0;
            shreg_nx   = '0;
          end
        end

        S_DATA: begin
          // Right shift with the new bit entering at the MSB; after DATA_W
          // samples the first (LSB) bit has reached bit 0. Written as a shift
          // of the concatenation so it also holds for DATA_W = 1.
          shreg_nx   = DATA_W'({din, shreg} >> 1);
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state_nx = PARITY_EN ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          par_bit_nx = din;
          state_nx   = S_STOP;
        end

        S_STOP: begin
          if (din) begin
            state_nx = S_IDLE;
            if (parity_ok) valid_nx = 1'b1;
            else           perr_nx  = 1'b1;
          end else begin
            // Framing error wins over any parity result for this frame.
            ferr_nx  = 1'b1;
            state_nx = S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          // A held-low line must return high before a new start bit counts.
          if (din) state_nx = S_IDLE;
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      par_bit    <= par_bit_nx;
      // Pulses are decoded only on a strobe, so they last exactly one clk
      // regardless of strobe spacing.
      data_valid <= valid_nx;
      parity_err <= perr_nx;
      frame_err  <= ferr_nx;
      busy       <= (state_nx != S_IDLE);
      if (valid_nx) data_out <= shreg;
    end
  end

endmodule
